// File: rtl/eq_dsp_pkg.sv
// Shared definitions for the equalizer DSP blocks: sample format, default
// delay-line geometry and the tap-scan FSM encoding.
package eq_dsp_pkg;

    localparam int SAMPLE_W       = 16;
    localparam int DEFAULT_DEPTH  = 64;
    localparam int DEFAULT_NUM_CH = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // A single-channel build still needs a 1-bit channel field.
    function automatic int chWidth(input int numCh);
        return (numCh > 1) ? $clog2(numCh) : 1;
    endfunction

endpackage

// File: rtl/tap_ring_buffer.sv
// One channel of history: DEPTH-entry circular buffer with write pointer,
// saturating fill count and NUM_RD asynchronous tap-fetch ports.
module tap_ring_buffer
    import eq_dsp_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int NUM_RD = 2,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     wr_en_i,
    input  logic signed [DATA_W-1:0] wr_data_i,
    input  logic        [IDX_W-1:0]  rd_idx_i  [NUM_RD],
    output logic signed [DATA_W-1:0] rd_data_o [NUM_RD]
);

    localparam logic [IDX_W:0] FILL_FULL = (IDX_W+1)'(DEPTH);

    logic signed [DATA_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0] wrPtr_q, wrPtr_d;
    logic [IDX_W:0]   fill_q, fill_d;

    always_comb begin
        wrPtr_d = wrPtr_q;
        fill_d  = fill_q;
        if (flush_i) begin
            wrPtr_d = '0;
            fill_d  = '0;
        end else if (wr_en_i) begin
            wrPtr_d = wrPtr_q + 1'b1;
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            fill_q  <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            fill_q  <= fill_d;
        end
    end

    // Storage needs no reset: entries beyond the fill count are never exposed.
    always_ff @(posedge clk) begin
        if (wr_en_i && !flush_i) begin
            mem_q[wrPtr_d] <= wr_data_i;
        end
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : gRd
        assign rd_data_o[r] = ({1'b0, rd_idx_i[r]} < fill_q) ? mem_q[wrPtr_q - rd_idx_i[r]] : '0;
    end

endmodule

// File: rtl/multich_tap_delay_line.sv
// Multi-channel tap delay line: accepts one sample, then streams every tap newest-first.
// Define SYMMETRIC_TAP_EN to stream DEPTH/2 pre-added symmetric tap pairs instead.
module multich_tap_delay_line
    import eq_dsp_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int NUM_CH = DEFAULT_NUM_CH,
    localparam int CH_W  = chWidth(NUM_CH),
    localparam int IDX_W = $clog2(DEPTH),
`ifdef SYMMETRIC_TAP_EN
    localparam int TAP_W = DATA_W + 1,
    localparam int NTAP  = DEPTH / 2,
    localparam int NRD   = 2
`else
    localparam int TAP_W = DATA_W,
    localparam int NTAP  = DEPTH,
    localparam int NRD   = 1
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [CH_W-1:0]   i_ch,
    input  logic [DATA_W-1:0] i_sample,
    input  logic              i_flush,
    output logic              o_tap_valid,
    output logic              o_tap_last,
    output logic [IDX_W-1:0]  o_tap_idx,
    output logic [CH_W-1:0]   o_tap_ch,
    output logic [TAP_W-1:0]  o_tap,
    output logic              o_ch_err
);

    scan_state_e      state_q, state_d;
    logic [IDX_W-1:0] tapCnt_q, tapCnt_d;
    logic [CH_W-1:0]  scanCh_q, scanCh_d;
    logic             chErr_q, chErr_d;

    logic consume, chOk, accept, lastTap;
    logic [IDX_W-1:0]         rdIdx  [NRD];
    logic signed [DATA_W-1:0] rdData [NUM_CH][NRD];
    logic [TAP_W-1:0]         tapValue;

    assign o_ready = (state_q == ST_IDLE) & ~i_flush;
    assign chOk    = int'(i_ch) < NUM_CH;
    assign consume = i_valid & o_ready;
    assign accept  = consume & chOk;
    assign lastTap = (tapCnt_q == IDX_W'(NTAP - 1));

    for (genvar c = 0; c < NUM_CH; c++) begin : gCh
        tap_ring_buffer #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .NUM_RD (NRD)
        ) uRing (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush_i   (i_flush),
            .wr_en_i   (accept && (int'(i_ch) == c)),
            .wr_data_i (i_sample),
            .rd_idx_i  (rdIdx),
            .rd_data_o (rdData[c])
        );
    end

    assign rdIdx[0] = tapCnt_q;
`ifdef SYMMETRIC_TAP_EN
    // Mirror tap DEPTH-1-k is the bitwise complement of k for a power-of-2 depth.
    assign rdIdx[1] = ~tapCnt_q;
    assign tapValue = {rdData[scanCh_q][0][DATA_W-1], rdData[scanCh_q][0]}
                    + {rdData[scanCh_q][1][DATA_W-1], rdData[scanCh_q][1]};
`else
    assign tapValue = rdData[scanCh_q][0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            tapCnt_q <= '0;
            scanCh_q <= '0;
            chErr_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tapCnt_q <= tapCnt_d;
            scanCh_q <= scanCh_d;
            chErr_q  <= chErr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tapCnt_d = tapCnt_q;
        scanCh_d = scanCh_q;
        chErr_d  = consume & ~chOk;
        if (i_flush) begin
            state_d  = ST_IDLE;
            tapCnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d  = ST_SCAN;
                        tapCnt_d = '0;
                        scanCh_d = i_ch;
                    end
                end
                ST_SCAN: begin
                    if (lastTap) begin
                        state_d  = ST_IDLE;
                        tapCnt_d = '0;
                    end else begin
                        tapCnt_d = tapCnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_tap_valid = (state_q == ST_SCAN);
        o_tap_last  = o_tap_valid & lastTap;
        o_tap_idx   = o_tap_valid ? tapCnt_q : '0;
        o_tap_ch    = o_tap_valid ? scanCh_q : '0;
        o_tap       = o_tap_valid ? tapValue : '0;
        o_ch_err    = chErr_q;
    end

endmodule

// File: tb/tb_multich_tap_delay_line.sv
// Self-checking bench for multich_tap_delay_line against a queue-based history model.
// Three channels are instantiated so that an out-of-range i_ch (3) is representable.
module tb_multich_tap_delay_line;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 64;
    localparam int NUM_CH = 3;
    localparam int CH_W   = 2;
    localparam int IDX_W  = 6;
`ifdef SYMMETRIC_TAP_EN
    localparam int TAP_W  = DATA_W + 1;
    localparam int NTAP   = DEPTH / 2;
`else
    localparam int TAP_W  = DATA_W;
    localparam int NTAP   = DEPTH;
`endif

    logic              clk;
    logic              rst_n;
    logic              i_valid;
    logic              o_ready;
    logic [CH_W-1:0]   i_ch;
    logic [DATA_W-1:0] i_sample;
    logic              i_flush;
    logic              o_tap_valid;
    logic              o_tap_last;
    logic [IDX_W-1:0]  o_tap_idx;
    logic [CH_W-1:0]   o_tap_ch;
    logic [TAP_W-1:0]  o_tap;
    logic              o_ch_err;

    int nCompared   = 0;
    int nMismatched = 0;

    // Newest sample at index 0; at most DEPTH entries kept per channel.
    int hist [NUM_CH][$];

    typedef struct {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] sample;
        logic              expScan;
        logic              expErr;
    } vec_t;

    vec_t vecs [8];

    multich_tap_delay_line #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .NUM_CH (NUM_CH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_ch        (i_ch),
        .i_sample    (i_sample),
        .i_flush     (i_flush),
        .o_tap_valid (o_tap_valid),
        .o_tap_last  (o_tap_last),
        .o_tap_idx   (o_tap_idx),
        .o_tap_ch    (o_tap_ch),
        .o_tap       (o_tap),
        .o_ch_err    (o_ch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [TAP_W-1:0] modelTap(input int ch, input int k);
        int a;
        int b;
        a = (k < hist[ch].size()) ? hist[ch][k] : 0;
`ifdef SYMMETRIC_TAP_EN
        b = ((DEPTH - 1 - k) < hist[ch].size()) ? hist[ch][DEPTH - 1 - k] : 0;
`else
        b = 0;
`endif
        return TAP_W'(a + b);
    endfunction

    task automatic clearModel();
        for (int c = 0; c < NUM_CH; c++) hist[c].delete();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Offers one sample and returns at the falling edge of the cycle after the accept edge.
    task automatic applyStimulus(input int ch, input logic [DATA_W-1:0] s);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!o_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!o_ready) checkOutput("readyTimeout", {31'b0, o_ready}, 32'd1);
        i_valid  = 1'b1;
        i_ch     = CH_W'(ch);
        i_sample = s;
        @(negedge clk);
        i_valid  = 1'b0;
        if (ch < NUM_CH) begin
            hist[ch].push_front(int'($signed(s)));
            if (hist[ch].size() > DEPTH) void'(hist[ch].pop_back());
        end
    endtask

    task automatic checkScan(input int ch);
        for (int k = 0; k < NTAP; k++) begin
            checkOutput($sformatf("tapValid k=%0d", k), {31'b0, o_tap_valid}, 32'd1);
            checkOutput($sformatf("tapIdx k=%0d", k), {26'b0, o_tap_idx}, k);
            checkOutput($sformatf("tapCh k=%0d", k), {30'b0, o_tap_ch}, ch);
            checkOutput($sformatf("tapLast k=%0d", k), {31'b0, o_tap_last}, {31'b0, (k == NTAP - 1)});
            checkOutput($sformatf("tapData ch=%0d k=%0d", ch, k), 32'(o_tap), 32'(modelTap(ch, k)));
            checkOutput($sformatf("readyLow k=%0d", k), {31'b0, o_ready}, 32'd0);
            @(negedge clk);
        end
        checkOutput("scanEnd", {31'b0, o_tap_valid}, 32'd0);
        checkOutput("readyBack", {31'b0, o_ready}, 32'd1);
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, " valid"}, {31'b0, o_tap_valid}, 32'd0);
        checkOutput({name, " last"}, {31'b0, o_tap_last}, 32'd0);
        checkOutput({name, " idx"}, {26'b0, o_tap_idx}, 32'd0);
        checkOutput({name, " ch"}, {30'b0, o_tap_ch}, 32'd0);
        checkOutput({name, " tap"}, 32'(o_tap), 32'd0);
        checkOutput({name, " ready"}, {31'b0, o_ready}, 32'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_ch     = '0;
        i_sample = '0;
        i_flush  = 1'b0;

        vecs[0] = '{2'd0, 16'h0100, 1'b1, 1'b0};
        vecs[1] = '{2'd1, 16'h7FFF, 1'b1, 1'b0};
        vecs[2] = '{2'd0, 16'h0100, 1'b1, 1'b0};
        vecs[3] = '{2'd1, 16'h7FFF, 1'b1, 1'b0};
        vecs[4] = '{2'd3, 16'h1111, 1'b0, 1'b1};
        vecs[5] = '{2'd0, 16'h0100, 1'b1, 1'b0};
        vecs[6] = '{2'd1, 16'h7FFF, 1'b1, 1'b0};
        vecs[7] = '{2'd2, 16'h8000, 1'b1, 1'b0};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkIdle("reset");
        checkOutput("reset chErr", {31'b0, o_ch_err}, 32'd0);
        rst_n = 1'b1;
        clearModel();

        // Single impulse into an all-zero history
        applyStimulus(0, 16'h4000);
        checkScan(0);

        // Wrap-around and fill saturation
        for (int n = 1; n <= 70; n++) begin
            applyStimulus(0, 16'(n));
            checkScan(0);
        end

        // Interleaved channels plus an out-of-range channel
        for (int v = 0; v < 8; v++) begin
            applyStimulus(int'(vecs[v].ch), vecs[v].sample);
            checkOutput($sformatf("vec%0d chErr", v), {31'b0, o_ch_err}, {31'b0, vecs[v].expErr});
            checkOutput($sformatf("vec%0d scanStart", v), {31'b0, o_tap_valid}, {31'b0, vecs[v].expScan});
            if (vecs[v].expScan) begin
                checkScan(int'(vecs[v].ch));
            end else begin
                @(negedge clk);
                checkOutput($sformatf("vec%0d errClear", v), {31'b0, o_ch_err}, 32'd0);
                checkOutput($sformatf("vec%0d noScan", v), {31'b0, o_tap_valid}, 32'd0);
            end
        end

        // Flush aborts a scan at k=10 and blocks a simultaneous offer
        applyStimulus(1, 16'h0ABC);
        for (int k = 0; k < 10; k++) @(negedge clk);
        checkOutput("preFlush idx", {26'b0, o_tap_idx}, 32'd10);
        i_flush  = 1'b1;
        i_valid  = 1'b1;
        i_ch     = 2'd0;
        i_sample = 16'h1234;
        #1;
        checkOutput("flush readyLow", {31'b0, o_ready}, 32'd0);
        @(negedge clk);
        i_flush = 1'b0;
        i_valid = 1'b0;
        clearModel();
        checkOutput("flush abort valid", {31'b0, o_tap_valid}, 32'd0);
        checkOutput("flush abort last", {31'b0, o_tap_last}, 32'd0);
        @(negedge clk);
        checkIdle("postFlush");
        applyStimulus(0, 16'd5);
        checkScan(0);
        applyStimulus(1, 16'hFFFF);
        checkScan(1);

        // Full line of positive full-scale samples
        for (int n = 0; n < DEPTH; n++) begin
            applyStimulus(2, 16'h7FFF);
            checkScan(2);
        end

        // Randomised traffic including out-of-range channels
        for (int n = 0; n < 30; n++) begin
            int ch;
            logic [DATA_W-1:0] s;
            ch = int'($urandom_range(0, 3));
            s  = 16'($urandom);
            applyStimulus(ch, s);
            if (ch < NUM_CH) begin
                checkScan(ch);
            end else begin
                checkOutput("rand chErr", {31'b0, o_ch_err}, 32'd1);
                checkOutput("rand noScan", {31'b0, o_tap_valid}, 32'd0);
            end
        end

        // Asynchronous reset mid-scan
        applyStimulus(2, 16'h2222);
        for (int k = 0; k < 5; k++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkIdle("asyncReset");
        @(negedge clk);
        rst_n = 1'b1;
        clearModel();
        applyStimulus(2, 16'h0033);
        checkScan(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
